ram_block_mover: RTL and testbench

- Sequencing engine that sits directly upstream of the single-port SRAM macro (CEN/WEN/OEN active-low interface) and is the only master of its port.
- Accepts one command at a time: block copy (read src, write dst) or block fill (write a constant word) over LEN consecutive addresses.
- Used to move and clear GF(2^m) operand/matrix rows in SRAM without processor involvement. Reports BUSY and a one-cycle DONE.

---
 rtl/ram_block_mover.sv | 123 ++++++++++++
 tb/tb_ram_block_mover.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_mover.sv
// Block copy / block fill sequencer; sole master of a single-port SRAM with
// active-low CEN/WEN/OEN controls.
//
// state | meaning
// IDLE  | waiting for START; LEN=0 commands complete here with a DONE pulse
// RD    | copy: SRAM reads src, data appears on RAM_Q after this edge
// WR    | copy: SRAM writes RAM_Q (last read word) to dst
// FL    | fill: one write of the latched fill word per cycle
module ram_block_mover #(
  parameter int AddressWidth = 12,
  parameter int DataWidth    = 144,
  parameter int LenWidth     = 13
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    MODE,
  input  logic [AddressWidth-1:0] SRC_A,
  input  logic [AddressWidth-1:0] DST_A,
  input  logic [LenWidth-1:0]     LEN,
  input  logic [DataWidth-1:0]    FILL_D,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [AddressWidth-1:0] RAM_A,
  output logic [DataWidth-1:0]    RAM_D,
  input  logic [DataWidth-1:0]    RAM_Q,
  output logic                    RAM_CEN,
  output logic                    RAM_WEN,
  output logic                    RAM_OEN
);

  typedef enum logic [1:0] {IDLE, RD, WR, FL} state_t;

  state_t                  state;
  logic [AddressWidth-1:0] src_q;
  logic [AddressWidth-1:0] dst_q;
  logic [LenWidth-1:0]     remain_q;
  logic [DataWidth-1:0]    fill_q;
  logic                    last_word;

  assign last_word = (remain_q == LenWidth'(1));

  // Copy writes the word read in the preceding RD cycle straight from RAM_Q.
  assign RAM_D   = (state == WR) ? RAM_Q : fill_q;
  assign RAM_OEN = 1'b0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      fill_q   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      RAM_A    <= '0;
      RAM_CEN  <= 1'b1;
      RAM_WEN  <= 1'b1;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            dst_q    <= DST_A;
            remain_q <= LEN;
            fill_q   <= FILL_D;
            if (!MODE) src_q <= SRC_A;
            if (LEN == '0) begin
              DONE <= 1'b1;
            end else if (!MODE) begin
              state   <= RD;
              RAM_A   <= SRC_A;
              RAM_CEN <= 1'b0;
              RAM_WEN <= 1'b1;
              BUSY    <= 1'b1;
            end else begin
              state   <= FL;
              RAM_A   <= DST_A;
              RAM_CEN <= 1'b0;
              RAM_WEN <= 1'b0;
              BUSY    <= 1'b1;
            end
          end
        end
        RD: begin
          state   <= WR;
          RAM_A   <= dst_q;
          RAM_WEN <= 1'b0;
          src_q   <= src_q + 1'b1;
        end
        WR: begin
          dst_q    <= dst_q + 1'b1;
          remain_q <= remain_q - 1'b1;
          if (!last_word) begin
            state   <= RD;
            RAM_A   <= src_q;
            RAM_WEN <= 1'b1;
          end else begin
            state   <= IDLE;
            RAM_CEN <= 1'b1;
            RAM_WEN <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
          end
        end
        FL: begin
          dst_q    <= dst_q + 1'b1;
          RAM_A    <= RAM_A + 1'b1;
          remain_q <= remain_q - 1'b1;
          if (last_word) begin
            state   <= IDLE;
            RAM_CEN <= 1'b1;
            RAM_WEN <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_block_mover.sv
// Scoreboard bench for ram_block_mover: a behavioural SRAM plus an
// address-level reference model that predicts every access and DONE pulse.
module tb_ram_block_mover;
  localparam int AW = 12;
  localparam int DW = 144;
  localparam int LW = 13;
  localparam int NW = 4096;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          MODE;
  logic [AW-1:0] SRC_A;
  logic [AW-1:0] DST_A;
  logic [LW-1:0] LEN;
  logic [DW-1:0] FILL_D;
  logic          BUSY;
  logic          DONE;
  logic [AW-1:0] RAM_A;
  logic [DW-1:0] RAM_D;
  logic [DW-1:0] RAM_Q;
  logic          RAM_CEN;
  logic          RAM_WEN;
  logic          RAM_OEN;

  always #5 CLK = ~CLK;

  ram_block_mover #(.AddressWidth(AW), .DataWidth(DW), .LenWidth(LW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .SRC_A(SRC_A),
    .DST_A(DST_A), .LEN(LEN), .FILL_D(FILL_D), .BUSY(BUSY), .DONE(DONE),
    .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_Q(RAM_Q), .RAM_CEN(RAM_CEN),
    .RAM_WEN(RAM_WEN), .RAM_OEN(RAM_OEN)
  );

  // SRAM model with a backdoor write port used only while the mover is idle
  logic [DW-1:0] sram_mem [NW];
  logic          bd_we;
  logic [AW-1:0] bd_a;
  logic [DW-1:0] bd_d;

  always @(posedge CLK) begin
    if (bd_we) sram_mem[bd_a] <= bd_d;
    else if (!RAM_CEN) begin
      if (!RAM_WEN) sram_mem[RAM_A] <= RAM_D;
      else          RAM_Q <= sram_mem[RAM_A];
    end
  end

  typedef struct {
    bit            is_done;
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [NW];
  int            total = 0;
  int            bad   = 0;

  task automatic check(input bit ok, input string name, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < 5; i++) w = {w[DW-33:0], 32'($urandom)};
    return w;
  endfunction

  task automatic push_exp(input bit is_done, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    exp_t e;
    e.is_done = is_done; e.wr = wr; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // Reference: ascending word-by-word move; limit >= 0 truncates after that many accesses
  task automatic model_cmd(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input int len, input logic [DW-1:0] fill, input int limit);
    int n = 0;
    logic [AW-1:0] s, d;
    for (int i = 0; i < len; i++) begin
      s = src + AW'(i);
      d = dst + AW'(i);
      if (limit >= 0 && n >= limit) return;
      if (mode) begin
        push_exp(0, 1, d, fill);
        ref_mem[d] = fill;
        n++;
      end else begin
        push_exp(0, 0, s, '0);
        n++;
        if (limit >= 0 && n >= limit) return;
        push_exp(0, 1, d, ref_mem[s]);
        ref_mem[d] = ref_mem[s];
        n++;
      end
    end
    if (limit < 0 || n < limit) push_exp(1, 0, '0, '0);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ref_mem[a] = d;
    bd_a = a; bd_d = d; bd_we = 1'b1;
    @(posedge CLK);
    #1 bd_we = 1'b0;
  endtask

  task automatic run_cmd(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input int len, input logic [DW-1:0] fill, input bit inject);
    int k = 0;
    int lat;
    lat = (len == 0) ? 0 : (mode ? len : 2 * len);
    model_cmd(mode, src, dst, len, fill, -1);
    MODE = mode; SRC_A = src; DST_A = dst; LEN = LW'(len); FILL_D = fill; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    MODE = 1'($urandom); SRC_A = AW'($urandom); DST_A = AW'($urandom);
    LEN = LW'($urandom_range(1, 9)); FILL_D = rand_word();
    @(negedge CLK);
    while (!DONE && k < lat + 20) begin
      if (inject && k == 1) START = 1'b1;
      if (inject && k == 2) START = 1'b0;
      @(posedge CLK);
      k++;
      @(negedge CLK);
    end
    START = 1'b0;
    check(DONE && k == lat, "latency",
          $sformatf("mode=%0d len=%0d done=%0b after %0d edges, want %0d", mode, len, DONE, k, lat));
  endtask

  // Monitor: every active SRAM cycle and every DONE pulse consumes one expectation
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      check(BUSY == !RAM_CEN, "busy_vs_cen",
            $sformatf("busy=%0b cen=%0b, want busy == !cen", BUSY, RAM_CEN));
      if (DONE || !RAM_CEN) begin
        if (exp_q.size() == 0) begin
          check(0, "unexpected",
                $sformatf("done=%0b cen=%0b a=%h with nothing expected", DONE, RAM_CEN, RAM_A));
        end else begin
          e = exp_q.pop_front();
          if (DONE)
            check(e.is_done && RAM_CEN, "done",
                  $sformatf("done with cen=%0b, want expected entry done=1 (got is_done=%0b a=%h)",
                            RAM_CEN, e.is_done, e.a));
          else
            check(!e.is_done && (RAM_WEN == !e.wr) && RAM_A == e.a && (!e.wr || RAM_D == e.d),
                  "access",
                  $sformatf("got wen=%0b a=%h d=%h, want done=%0b wen=%0b a=%h d=%h",
                            RAM_WEN, RAM_A, RAM_D, e.is_done, !e.wr, e.a, e.d));
        end
      end
    end
  end

  initial begin
    int mism;
    logic [AW-1:0] s, d;
    RST = 1'b1; START = 1'b0; MODE = 1'b0; SRC_A = '0; DST_A = '0; LEN = '0; FILL_D = '0;
    bd_we = 1'b0; bd_a = '0; bd_d = '0;
    #2;
    for (int i = 0; i < NW; i++) poke(AW'(i), rand_word());
    @(negedge CLK);
    check(RAM_CEN && RAM_WEN && RAM_A == '0 && !BUSY && !DONE, "reset_state",
          $sformatf("cen=%0b wen=%0b a=%h busy=%0b done=%0b, want 1 1 000 0 0",
                    RAM_CEN, RAM_WEN, RAM_A, BUSY, DONE));
    check(RAM_OEN == 1'b0, "oen", $sformatf("oen=%0b, want 0", RAM_OEN));
    RST = 1'b0;
    @(negedge CLK);

    run_cmd(1, '0, 12'h010, 4, {18{8'hA5}}, 0);
    poke(12'h010, 144'd1); poke(12'h011, 144'd2); poke(12'h012, 144'd3);
    run_cmd(0, 12'h010, 12'h100, 3, rand_word(), 0);
    check(sram_mem[12'h100] == 144'd1 && sram_mem[12'h101] == 144'd2 && sram_mem[12'h102] == 144'd3,
          "copy_result", $sformatf("100..102 = %0d %0d %0d, want 1 2 3",
                                   sram_mem[12'h100], sram_mem[12'h101], sram_mem[12'h102]));
    run_cmd(0, 12'h300, 12'h400, 0, rand_word(), 0);
    run_cmd(1, 12'h300, 12'h400, 0, rand_word(), 0);
    run_cmd(1, '0, 12'hFFE, 4, rand_word(), 0);
    poke(12'h020, 144'd7); poke(12'h021, 144'd9);
    run_cmd(0, 12'h020, 12'h021, 2, rand_word(), 1);
    check(sram_mem[12'h021] == 144'd7 && sram_mem[12'h022] == 144'd7, "overlap_result",
          $sformatf("021=%0d 022=%0d, want 7 7", sram_mem[12'h021], sram_mem[12'h022]));

    // Abort a 5-word copy right after its second write
    model_cmd(0, 12'h200, 12'h280, 5, '0, 4);
    MODE = 1'b0; SRC_A = 12'h200; DST_A = 12'h280; LEN = LW'(5); START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check(RAM_CEN && !BUSY && !DONE, "abort_idle",
          $sformatf("cen=%0b busy=%0b done=%0b, want 1 0 0", RAM_CEN, BUSY, DONE));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check(exp_q.size() == 0, "abort_drain",
          $sformatf("%0d expectations left, want 0", exp_q.size()));
    repeat (4) @(negedge CLK);
    run_cmd(0, 12'h200, 12'h2C0, 5, rand_word(), 0);

    for (int t = 0; t < 16; t++) begin
      s = ($urandom_range(0, 3) == 0) ? AW'(12'hFF0 + $urandom_range(0, 15)) : AW'($urandom);
      d = ($urandom_range(0, 3) == 0) ? AW'(12'hFF0 + $urandom_range(0, 15)) : AW'($urandom);
      run_cmd(1'($urandom), s, d, $urandom_range(0, 12), rand_word(), 1'($urandom));
    end
    run_cmd(1, '0, AW'($urandom), NW, rand_word(), 0);
    for (int i = 0; i < 8; i++) poke(AW'($urandom), rand_word());
    run_cmd(0, 12'h7F0, 12'h7F3, NW, rand_word(), 0);

    repeat (5) @(negedge CLK);
    check(exp_q.size() == 0, "queue_empty",
          $sformatf("%0d expectations left, want 0", exp_q.size()));
    mism = 0;
    for (int i = 0; i < NW; i++) begin
      if (sram_mem[i] !== ref_mem[i]) begin
        if (mism == 0)
          $display("FAIL mem_word: addr %h got %h want %h", i[AW-1:0], sram_mem[i], ref_mem[i]);
        mism++;
      end
    end
    check(mism == 0, "mem_final", $sformatf("%0d words differ, want 0", mism));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
